fifo_mrp: RTL and testbench
===========================

// Module: fifo_mrp
// PURPOSE
//  Single-write, multi-read-pointer FIFO (first-word-fall-through) for coefficient streams between NTT,
//  multiplier and adder stages; generalises the two-read-port buffer to NUM_RD independent readers.
//  One NTT output feeds several consumers (e.g. u consumed by b*u and a*u) without duplicating storage.
//  Adds per-reader polynomial-frame tracking (r_last), a runtime reader-enable mask and an occupancy output.
// PARAMETERS
//  DATA_WIDTH  5  coefficient width (logq)
//  ADDR_WIDTH  3  log2 of storage depth; DEPTH = 2**ADDR_WIDTH entries
//  NUM_RD      2  number of independent read ports, >=1
//  FRAME_LEN   8  coefficients per polynomial frame (N), >=2
// PORTS
//  clk       in   1                      clock, all state updates on rising edge
//  reset     in   1                      synchronous reset, active-high
//  w_en      in   1                      write strobe; accepted only when n_full=1
//  data_in   in   DATA_WIDTH             write data
//  n_full    out  1                      1 = space available for one write
//  rd_active in   NUM_RD                 reader enable mask; bit i=0 removes reader i
//  r_en      in   NUM_RD                 per-reader read strobe; accepted only when n_empty[i]=1
//  data_out  out  NUM_RD*DATA_WIDTH      reader i head word at [i*DATA_WIDTH +: DATA_WIDTH]
//  n_empty   out  NUM_RD                 1 = reader i has at least one unread word
//  r_last    out  NUM_RD                 1 = reader i head word is coefficient FRAME_LEN-1 of its frame
//  level     out  ADDR_WIDTH+1           occupancy seen by the slowest active reader (0..DEPTH)
// BEHAVIOUR
//  Storage: DEPTH x DATA_WIDTH array, not reset. wr_ptr and rd_ptr[i] are ADDR_WIDTH+1 bits and wrap mod 2*DEPTH.
//  occ[i] = wr_ptr - rd_ptr[i] (mod 2*DEPTH); level = max occ[i] over active readers, 0 if none active.
//  n_full = (level != DEPTH); n_empty[i] = rd_active[i] & (occ[i] != 0). Both depend only on registered
//    state and rd_active -- no combinational path from w_en or r_en.
//  Write: w_en & n_full -> mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in, wr_ptr++. w_en & !n_full -> dropped, no state change.
//  Read i: r_en[i] & n_empty[i] -> rd_ptr[i]++, frame_idx[i] <= (frame_idx[i]==FRAME_LEN-1) ? 0 : +1.
//    r_en[i] while n_empty[i]=0 -> ignored.
//  data_out slice i = mem[rd_ptr[i]] when n_empty[i]=1, else all zeros (FWFT; valid same cycle as n_empty).
//  r_last[i] = n_empty[i] & (frame_idx[i]==FRAME_LEN-1).
//  Simultaneous write+read, same cycle: both take effect; write at full is dropped even if the slowest reader
//    reads in that cycle (n_full reflects pre-edge state); read at empty ignored even if a write lands that cycle.
//  Written word becomes visible (n_empty rises) the cycle after the write edge; latency write->read = 1 cycle.
//  Inactive reader (rd_active[i]=0): each cycle rd_ptr[i] <= next wr_ptr (incl. write of this cycle),
//    frame_idx[i] <= 0; excluded from level/n_full. On re-enable it sees only words written after that edge.
//  Readers advance independently; the oldest entry is freed only when every active reader has consumed it.
//  Reset (reset=1 at edge): wr_ptr, rd_ptr[*], frame_idx[*] <= 0. Outputs after reset: n_full=1, n_empty=0,
//    r_last=0, level=0, data_out=0. Reset mid-operation discards all buffered data; memory contents irrelevant.
//  Illegal: FRAME_LEN<2 or NUM_RD<1 (elaboration error via generate check).
// TESTING  (DATA_WIDTH=5, ADDR_WIDTH=3, NUM_RD=2, FRAME_LEN=8, rd_active=2'b11 unless stated)
//  1 Fill: write 1..8 on 8 cycles, no reads -> level 1..8, n_full=0 after 8th; 9th write (value 9) dropped;
//    n_empty=2'b11, both data_out=1.
//  2 Skewed readers: after fill, reader0 drains 8 words, reader1 none -> n_full stays 0, level=8;
//    reader1 reads once -> next cycle n_full=1, level=7.
//  3 Frame marker: stream 16 values 0..15, both read continuously -> r_last[i]=1 exactly when data_out=7 and 15;
//    frame_idx wraps to 0 after each.
//  4 Simultaneous: at level=8, w_en=1 and r_en=2'b11 same cycle -> write dropped, level=7 next cycle;
//    at level=0, w_en=1 & r_en=1 -> read ignored, level=1.
//  5 Mask: rd_active=2'b01, write 8 words with reader0 draining -> n_full never 0, n_empty[1]=0;
//    set rd_active=2'b11, write 5 -> reader1 data_out=5, r_last[1]=0 (frame_idx=0).
//  6 Reset mid-stream: level=5, assert reset one cycle with w_en=1 -> level=0, n_empty=0, n_full=1,
//    data_out=0; the write in the reset cycle is not stored.

Source files
------------

// File: rtl/fifo_mrp.sv
//------------------------------------------------------------------------------
// fifo_mrp : single-write, multi-read-pointer first-word-fall-through FIFO
//            with per-reader frame tracking, reader-enable mask and occupancy.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_mrp #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_RD     = 2,
  parameter int FRAME_LEN  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         n_full,
  input  logic [NUM_RD-1:0]            rd_active,
  input  logic [NUM_RD-1:0]            r_en,
  output logic [NUM_RD*DATA_WIDTH-1:0] data_out,
  output logic [NUM_RD-1:0]            n_empty,
  output logic [NUM_RD-1:0]            r_last,
  output logic [ADDR_WIDTH:0]          level
);

  localparam int              DEPTH      = 1 << ADDR_WIDTH;
  localparam int              PW         = ADDR_WIDTH + 1;
  localparam int              FW         = $clog2(FRAME_LEN);
  localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAME_LEN - 1);
  localparam logic [PW-1:0]   DEPTH_CNT  = PW'(DEPTH);

  if (FRAME_LEN < 2 || NUM_RD < 1) begin : g_param_check
    $error("fifo_mrp: FRAME_LEN must be >= 2 and NUM_RD >= 1");
  end

  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                wr_ptr_nxt;
  logic                         wr_ok;
  logic [NUM_RD-1:0][PW-1:0]    occ;
  logic [PW-1:0]                level_c;

  assign wr_ok      = w_en & n_full;
  assign wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_ok};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !reset) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  // The slowest active reader bounds the free space; inactive readers never block writes.
  always_comb begin
    level_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_active[i] && (occ[i] > level_c)) begin
        level_c = occ[i];
      end
    end
  end

  assign level  = level_c;
  assign n_full = (level_c != DEPTH_CNT);

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [PW-1:0] rd_ptr;
    logic [FW-1:0] frame_idx;

    assign occ[gi]     = wr_ptr - rd_ptr;
    assign n_empty[gi] = rd_active[gi] & (occ[gi] != '0);
    assign r_last[gi]  = n_empty[gi] & (frame_idx == FRAME_LAST);
    assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
      n_empty[gi] ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;

    // A disabled reader shadows the write pointer so it resumes with fresh data only.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr    <= '0;
        frame_idx <= '0;
      end else if (!rd_active[gi]) begin
        rd_ptr    <= wr_ptr_nxt;
        frame_idx <= '0;
      end else if (r_en[gi] && n_empty[gi]) begin
        rd_ptr    <= rd_ptr + PW'(1);
        frame_idx <= (frame_idx == FRAME_LAST) ? '0 : frame_idx + FW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_mrp.sv
//------------------------------------------------------------------------------
// tb_fifo_mrp : directed and randomized checks of fifo_mrp against a
//               word-history model with per-reader positions.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_mrp;

  localparam int DW    = 5;
  localparam int AW    = 3;
  localparam int NR    = 2;
  localparam int FL    = 8;
  localparam int DEPTH = 8;
  localparam int HSZ   = 8192;

  logic            clk = 1'b0;
  logic            reset;
  logic            w_en;
  logic [DW-1:0]   data_in;
  logic            n_full;
  logic [NR-1:0]   rd_active;
  logic [NR-1:0]   r_en;
  logic [NR*DW-1:0] data_out;
  logic [NR-1:0]   n_empty;
  logic [NR-1:0]   r_last;
  logic [AW:0]     level;

  fifo_mrp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .w_en(w_en), .data_in(data_in), .n_full(n_full),
    .rd_active(rd_active), .r_en(r_en), .data_out(data_out), .n_empty(n_empty),
    .r_last(r_last), .level(level)
  );

  always #5 clk = ~clk;

  int npass  = 0;
  int ntotal = 0;

  task automatic check(string name, int act, int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: every accepted word appended to a history; each reader is an index into it.
  logic [DW-1:0] hist [HSZ];
  int  wcount = 0;
  int  pos  [NR];
  int  fidx [NR];
  bit  chk_en = 1'b0;

  function automatic int m_occ(int i);
    return wcount - pos[i];
  endfunction

  function automatic int m_level(logic [NR-1:0] act);
    int l = 0;
    for (int i = 0; i < NR; i++)
      if (act[i] && m_occ(i) > l) l = m_occ(i);
    return l;
  endfunction

  always @(posedge clk) begin : model
    int  lvl;
    bit  wr_ok;
    lvl = m_level(rd_active);
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        pos[i]  = wcount;
        fidx[i] = 0;
      end
    end else begin
      wr_ok = w_en && (lvl != DEPTH);
      for (int i = 0; i < NR; i++) begin
        if (!rd_active[i]) begin
          pos[i]  = wcount + (wr_ok ? 1 : 0);
          fidx[i] = 0;
        end else if (r_en[i] && m_occ(i) > 0) begin
          pos[i]++;
          fidx[i] = (fidx[i] + 1) % FL;
        end
      end
      if (wr_ok) begin
        hist[wcount % HSZ] = data_in;
        wcount++;
      end
    end
  end

  always @(negedge clk) begin : compare
    int lvl;
    bit ne;
    if (chk_en) begin
      lvl = m_level(rd_active);
      check("level", int'(level), lvl);
      check("n_full", int'(n_full), (lvl != DEPTH) ? 1 : 0);
      for (int i = 0; i < NR; i++) begin
        ne = rd_active[i] && (m_occ(i) > 0);
        check($sformatf("n_empty[%0d]", i), int'(n_empty[i]), ne ? 1 : 0);
        check($sformatf("data_out[%0d]", i), int'(data_out[i*DW +: DW]),
              ne ? int'(hist[pos[i] % HSZ]) : 0);
        check($sformatf("r_last[%0d]", i), int'(r_last[i]),
              (ne && fidx[i] == FL - 1) ? 1 : 0);
      end
    end
  end

  task automatic drive(bit w, logic [DW-1:0] d, logic [NR-1:0] r);
    w_en    = w;
    data_in = d;
    r_en    = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nl0, nl1, lsum;
    reset = 1'b1; w_en = 1'b0; data_in = '0; r_en = '0; rd_active = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_level", int'(level), 0);
    check("reset_n_full", int'(n_full), 1);
    check("reset_n_empty", int'(n_empty), 0);
    check("reset_data_out", int'(data_out), 0);
    reset = 1'b0;

    // Fill to the top, then one dropped write
    for (int v = 1; v <= 8; v++) begin
      drive(1'b1, DW'(v), 2'b00);
      check("fill_level", int'(level), v);
    end
    check("fill_n_full", int'(n_full), 0);
    drive(1'b1, 5'd9, 2'b00);
    check("drop_level", int'(level), 8);
    check("fill_n_empty", int'(n_empty), 3);
    check("fill_dout0", int'(data_out[4:0]), 1);
    check("fill_dout1", int'(data_out[9:5]), 1);

    // Skewed readers
    repeat (8) drive(1'b0, '0, 2'b01);
    check("skew_level", int'(level), 8);
    check("skew_n_full", int'(n_full), 0);
    check("skew_n_empty", int'(n_empty), 2);
    drive(1'b0, '0, 2'b10);
    check("skew_level7", int'(level), 7);
    check("skew_n_full1", int'(n_full), 1);
    check("skew_dout1", int'(data_out[9:5]), 2);
    repeat (7) drive(1'b0, '0, 2'b10);
    check("skew_drained", int'(level), 0);

    // Frame marker over a 16-word stream
    nl0 = 0; nl1 = 0; lsum = 0;
    for (int v = 0; v < 18; v++) begin
      drive(v < 16, DW'(v), 2'b11);
      if (r_last[0]) begin nl0++; lsum += int'(data_out[4:0]); end
      if (r_last[1]) nl1++;
    end
    check("frame_pulses0", nl0, 2);
    check("frame_pulses1", nl1, 2);
    check("frame_pulse_data", lsum, 22);

    // Simultaneous write and read at full and at empty
    for (int v = 0; v < 8; v++) drive(1'b1, DW'(v), 2'b00);
    check("sim_full", int'(level), 8);
    drive(1'b1, 5'd31, 2'b11);
    check("sim_full_level", int'(level), 7);
    check("sim_full_head", int'(data_out[4:0]), 1);
    repeat (7) drive(1'b0, '0, 2'b11);
    check("sim_empty", int'(level), 0);
    drive(1'b1, 5'd20, 2'b11);
    check("sim_empty_level", int'(level), 1);
    check("sim_empty_head", int'(data_out[4:0]), 20);
    drive(1'b0, '0, 2'b11);

    // Reader mask
    rd_active = 2'b01;
    for (int v = 1; v <= 8; v++) begin
      drive(1'b1, DW'(v), 2'b01);
      check("mask_n_full", int'(n_full), 1);
      check("mask_n_empty1", int'(n_empty[1]), 0);
    end
    drive(1'b0, '0, 2'b01);
    rd_active = 2'b11;
    drive(1'b1, 5'd5, 2'b00);
    check("mask_dout1", int'(data_out[9:5]), 5);
    check("mask_r_last1", int'(r_last[1]), 0);
    check("mask_level", int'(level), 1);
    drive(1'b0, '0, 2'b11);

    // Reset mid-stream
    for (int v = 0; v < 5; v++) drive(1'b1, DW'(v + 10), 2'b00);
    check("rst_pre_level", int'(level), 5);
    reset = 1'b1;
    drive(1'b1, 5'd9, 2'b00);
    reset = 1'b0;
    check("rst_level", int'(level), 0);
    check("rst_n_empty", int'(n_empty), 0);
    check("rst_n_full", int'(n_full), 1);
    check("rst_data_out", int'(data_out), 0);
    drive(1'b0, '0, 2'b00);
    check("rst_no_store", int'(level), 0);

    // Randomized traffic with alternating fill/drain bias
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) rd_active = NR'($urandom);
      reset = ($urandom_range(299) == 0);
      if (((c / 256) % 2) == 0)
        drive($urandom_range(3) != 0, DW'($urandom), NR'($urandom));
      else
        drive($urandom_range(3) == 0, DW'($urandom), NR'($urandom) | NR'($urandom));
    end
    reset = 1'b0;
    drive(1'b0, '0, 2'b00);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire
